// File: rtl/char_token_fsm.sv
// char_token_fsm
//   Recognises letters-then-digits tokens closed by a terminator character
//   (e.g. "abcd123%"). Each accepted token gives a one-cycle out pulse and
//   bumps match_cnt.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   char_valid : char is consumed only when high
//   char       : character code, ASCII in [7:0]
//   case_mode  : 0 = a-z and A-Z are letters, 1 = a-z only
//   out        : registered one-cycle accept pulse
//   match_cnt  : accepted token count, wraps
//   busy       : registered, high whenever state is not IDLE
//
// state | meaning
// IDLE  | waiting for the first letter of a token
// ALPHA | collecting letters
// NUM   | collecting digits, a terminator here may accept
// ERR   | malformed token, discard until a terminator
module char_token_fsm #(
   parameter int WIDTH     = 8,
   parameter int MIN_ALPHA = 1,
   parameter int MIN_DIGIT = 1,
   parameter int MAX_DIGIT = 3,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             char_valid,
   input  logic [WIDTH-1:0] char,
   input  logic             case_mode,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy
);

   localparam int A_W = (MIN_ALPHA < 1) ? 1 : $clog2(MIN_ALPHA + 1);
   localparam int D_W = $clog2(MAX_DIGIT + 1);

   localparam logic [A_W-1:0] A_MIN = A_W'(MIN_ALPHA);
   localparam logic [D_W-1:0] D_MIN = D_W'(MIN_DIGIT);
   localparam logic [D_W-1:0] D_MAX = D_W'(MAX_DIGIT);
   localparam logic [A_W-1:0] A_ONE = A_W'(1);
   localparam logic [D_W-1:0] D_ONE = D_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALPHA = 2'd1,
      NUM   = 2'd2,
      ERR   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      C_OTHER  = 2'd0,
      C_LETTER = 2'd1,
      C_DIGIT  = 2'd2
   } cls_t;

   state_t         state;
   logic [A_W-1:0] a_cnt;
   logic [D_W-1:0] d_cnt;
   cls_t           cls;
   logic           high_bits;
   logic [7:0]     lo;

   always_comb begin
      high_bits = 1'b0;
      if (WIDTH > 8) high_bits = |(char >> 8);
      lo  = char[7:0];
      cls = C_OTHER;
      if (!high_bits) begin
         if (lo >= 8'h30 && lo <= 8'h39)
            cls = C_DIGIT;
         else if (lo >= 8'h61 && lo <= 8'h7a)
            cls = C_LETTER;
         else if (lo >= 8'h41 && lo <= 8'h5a && !case_mode)
            cls = C_LETTER;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_cnt     <= '0;
         d_cnt     <= '0;
         out       <= 1'b0;
         match_cnt <= '0;
         busy      <= 1'b0;
      end else begin
         out <= 1'b0;
         if (char_valid) begin
            case (state)
               IDLE: begin
                  if (cls == C_LETTER) begin
                     state <= ALPHA;
                     a_cnt <= A_ONE;
                     busy  <= 1'b1;
                  end else if (cls == C_DIGIT) begin
                     state <= ERR;
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               ALPHA: begin
                  if (cls == C_LETTER) begin
                     // only "enough letters" matters, so stop at the minimum
                     if (a_cnt < A_MIN) a_cnt <= a_cnt + A_ONE;
                  end else if (cls == C_DIGIT) begin
                     if (a_cnt >= A_MIN) begin
                        state <= NUM;
                        d_cnt <= D_ONE;
                     end else begin
                        state <= ERR;
                     end
                  end else begin
                     state <= IDLE;
                     a_cnt <= '0;
                     busy  <= 1'b0;
                  end
               end
               NUM: begin
                  if (cls == C_DIGIT) begin
                     if (d_cnt == D_MAX) state <= ERR;
                     else                d_cnt <= d_cnt + D_ONE;
                  end else if (cls == C_LETTER) begin
                     state <= ERR;
                  end else begin
                     state <= IDLE;
                     a_cnt <= '0;
                     d_cnt <= '0;
                     busy  <= 1'b0;
                     if (d_cnt >= D_MIN) begin
                        out       <= 1'b1;
                        match_cnt <= match_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  if (cls == C_OTHER) begin
                     state <= IDLE;
                     a_cnt <= '0;
                     d_cnt <= '0;
                     busy  <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_char_token_fsm.sv
module tb_char_token_fsm;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance
   logic       reset, char_valid, case_mode;
   logic [7:0] char;
   logic       out;
   logic [7:0] match_cnt;
   logic       busy;

   // WIDTH=9, CNT_W=2 instance
   logic       reset1, char_valid1;
   logic [8:0] char1;
   logic       out1;
   logic [1:0] match_cnt1;
   logic       busy1;

   char_token_fsm dut (
      .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
      .case_mode(case_mode), .out(out), .match_cnt(match_cnt), .busy(busy)
   );

   char_token_fsm #(.WIDTH(9), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset1), .char_valid(char_valid1), .char(char1),
      .case_mode(1'b0), .out(out1), .match_cnt(match_cnt1), .busy(busy1)
   );

   typedef struct {
      logic       rst;
      logic       vld;
      logic       cm;
      logic [7:0] ch;
      logic       e_out;
      logic       e_busy;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs[$];
   int total = 0;
   int bad   = 0;

   task automatic add(input logic r, input logic v, input logic m, input logic [7:0] c,
                      input logic eo, input logic eb, input logic [7:0] ec);
      vec_t t;
      t.rst = r; t.vld = v; t.cm = m; t.ch = c;
      t.e_out = eo; t.e_busy = eb; t.e_cnt = ec;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step1(input logic r, input logic v, input logic [8:0] c,
                        input logic eo, input logic eb, input logic [1:0] ec, input string nm);
      reset1 = r; char_valid1 = v; char1 = c;
      @(posedge clk); #1;
      check({nm, ".out"},  int'(out1), int'(eo));
      check({nm, ".busy"}, int'(busy1), int'(eb));
      check({nm, ".cnt"},  int'(match_cnt1), int'(ec));
   endtask

   initial begin
      reset = 1'b1; char_valid = 1'b0; case_mode = 1'b0; char = 8'h00;
      reset1 = 1'b1; char_valid1 = 1'b0; char1 = 9'h000;

      // reset, with valid letter present: reset wins
      add(1,1,0,"a", 0,0,0);
      // abcd123% : accept at exactly MAX_DIGIT digits
      add(0,1,0,"a", 0,1,0); add(0,1,0,"b", 0,1,0); add(0,1,0,"c", 0,1,0);
      add(0,1,0,"d", 0,1,0); add(0,1,0,"1", 0,1,0); add(0,1,0,"2", 0,1,0);
      add(0,1,0,"3", 0,1,0); add(0,1,0,"%", 1,0,1);
      add(0,1,0," ", 0,0,1);                       // pulse lasts one cycle
      // ab1234<sp> : fourth digit overflows into ERR
      add(0,1,0,"a", 0,1,1); add(0,1,0,"b", 0,1,1); add(0,1,0,"1", 0,1,1);
      add(0,1,0,"2", 0,1,1); add(0,1,0,"3", 0,1,1); add(0,1,0,"4", 0,1,1);
      add(0,1,0," ", 0,0,1);
      add(0,1,0,"z", 0,1,1); add(0,1,0,"9", 0,1,1); add(0,1,0,"%", 1,0,2);
      // 1ab2% : leading digit errors
      add(0,1,0,"1", 0,1,2); add(0,1,0,"a", 0,1,2); add(0,1,0,"b", 0,1,2);
      add(0,1,0,"2", 0,1,2); add(0,1,0,"%", 0,0,2);
      add(0,1,0,"x", 0,1,2); add(0,1,0,"9", 0,1,2); add(0,1,0,"9", 0,1,2);
      add(0,1,0,"%", 1,0,3);
      // A1% with case_mode=1: 'A' is OTHER, '1' errors
      add(0,1,1,"A", 0,0,3); add(0,1,1,"1", 0,1,3); add(0,1,1,"%", 0,0,3);
      // A1% with case_mode=0
      add(0,1,0,"A", 0,1,3); add(0,1,0,"1", 0,1,3); add(0,1,0,"%", 1,0,4);
      // a% : letters with no digit never accept
      add(0,1,0,"a", 0,1,4); add(0,1,0,"%", 0,0,4);
      // invalid cycles hold state
      add(0,1,0,"a", 0,1,4); add(0,0,0,"%", 0,1,4); add(0,0,0,"%", 0,1,4);
      add(0,0,0,"%", 0,1,4); add(0,1,0,"5", 0,1,4); add(0,1,0,"%", 1,0,5);
      // reset mid-token discards it
      add(0,1,0,"a", 0,1,5); add(0,1,0,"b", 0,1,5); add(0,1,0,"1", 0,1,5);
      add(0,1,0,"2", 0,1,5); add(1,0,0,"%", 0,0,0); add(0,1,0,"%", 0,0,0);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; char_valid = vecs[i].vld;
         case_mode = vecs[i].cm; char = vecs[i].ch;
         @(posedge clk); #1;
         check($sformatf("v%0d.out", i),  int'(out),       int'(vecs[i].e_out));
         check($sformatf("v%0d.busy", i), int'(busy),      int'(vecs[i].e_busy));
         check($sformatf("v%0d.cnt", i),  int'(match_cnt), int'(vecs[i].e_cnt));
      end
      char_valid = 1'b0; reset = 1'b0;

      // WIDTH=9: 9'h161 has bit 8 set, so it is OTHER, not 'a'
      step1(1, 0, 9'h000, 0, 0, 0, "w9.rst");
      step1(0, 1, 9'h161, 0, 0, 0, "w9.hi");
      step1(0, 1, 9'h061, 0, 1, 0, "w9.a");
      step1(0, 1, 9'h025, 0, 0, 0, "w9.term");
      // CNT_W=2 wraps: 1,2,3,0,1
      for (int k = 0; k < 5; k++) begin
         step1(0, 1, 9'h071, 0, 1, 2'(k),     $sformatf("wrap%0d.q", k));
         step1(0, 1, 9'h037, 0, 1, 2'(k),     $sformatf("wrap%0d.7", k));
         step1(0, 1, 9'h025, 1, 0, 2'(k + 1), $sformatf("wrap%0d.t", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
